// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if: CALL/RET push/pop request and stack status bundle.
interface return_addr_stack_if #(parameter int AW = 8);
    logic          push_en;
    logic [AW-1:0] push_addr;
    logic          pop_en;
    logic [AW-1:0] ret_addr;
    logic          ret_valid;
    logic [AW-1:0] top_addr;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    modport master (output push_en, push_addr, pop_en,
                    input  ret_addr, ret_valid, top_addr, empty, full, overflow, underflow);
    modport slave  (input  push_en, push_addr, pop_en,
                    output ret_addr, ret_valid, top_addr, empty, full, overflow, underflow);
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: DEPTH-level return-address stack; RAS_WRAP_EN makes a push while full overwrite the oldest entry.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 8
) (
    input logic               clk,
    input logic               rst,
    return_addr_stack_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
`ifdef RAS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wp, tp, wp_n, wr_idx;
    logic [PW:0]   count, count_n;
    logic [AW-1:0] ret_addr;
    logic          ret_valid, overflow, underflow;
    logic          pop_ok, repl, push_ok, push_full, pop_only, adv, wr_en;
    assign tp        = wp - 1'b1;
    assign pop_ok    = bus.pop_en && count != '0;
    assign repl      = bus.push_en && pop_ok;
    assign pop_only  = pop_ok && !bus.push_en;
    assign push_ok   = bus.push_en && !pop_ok && !bus.full;
    assign push_full = bus.push_en && !pop_ok && bus.full;
    assign adv       = push_ok || (WRAP && push_full);
    always_comb begin
        wr_en   = repl || adv;
        wr_idx  = repl ? tp : wp;
        wp_n    = adv ? wp + 1'b1 : pop_only ? tp : wp;
        count_n = push_ok ? count + 1'b1 : pop_only ? count - 1'b1 : count;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            count     <= '0;
            ret_addr  <= '0;
            ret_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wp        <= wp_n;
            count     <= count_n;
            ret_valid <= pop_ok;
            if (pop_ok) ret_addr <= mem[tp];
            if (push_full) overflow <= 1'b1;
            if (bus.pop_en && !pop_ok) underflow <= 1'b1;
        end
    end
    // Storage is left uninitialised; only the pointers are reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_idx] <= bus.push_addr;
    end
    assign bus.ret_addr  = ret_addr;
    assign bus.ret_valid = ret_valid;
    assign bus.empty     = count == '0;
    assign bus.full      = count == (PW+1)'(DEPTH);
    assign bus.top_addr  = bus.empty ? '0 : mem[tp];
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule
